// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
package pc_pkg;

  localparam int DEF_INDEX_WIDTH = 9;
  localparam int DEF_INC         = 1;
  localparam int DEF_RESET_VEC   = 0;
  localparam int DEF_RAS_DEPTH   = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JMP,
    SEL_BR,
    SEL_INC
  } pc_sel_e;

  // Only one source may steer the PC per cycle; stall wins over everything.
  function automatic pc_sel_e next_sel(input logic stall,
                                       input logic ret,
                                       input logic call,
                                       input logic jump,
                                       input logic branch_taken);
    if (stall)             return SEL_HOLD;
    else if (ret)          return SEL_RET;
    else if (call)         return SEL_CALL;
    else if (jump)         return SEL_JMP;
    else if (branch_taken) return SEL_BR;
    else                   return SEL_INC;
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Return-address stack: circular buffer whose oldest entry is overwritten on overflow.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign top   = mem[ptr];
  assign ovf   = push & full;
  assign unf   = pop & empty;

  // ptr always addresses the newest entry; a push while full lands on the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr + PW'(1)] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with next-PC priority select and return-address stack.
// Optional retire counter output enabled by defining PC_RETIRE_CNT_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int INC         = DEF_INC,
  parameter int RESET_VEC   = DEF_RESET_VEC,
  parameter int RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [INDEX_WIDTH-1:0] branch_target,
  input  logic                   jump,
  input  logic                   call,
  input  logic                   ret,
  input  logic [INDEX_WIDTH-1:0] jump_target,
  output logic [INDEX_WIDTH-1:0] pc,
  output logic [INDEX_WIDTH-1:0] pc_plus,
  output logic                   ras_empty,
  output logic                   ras_full,
  output logic                   ras_err
`ifdef PC_RETIRE_CNT_EN
  ,
  output logic [31:0]            retire_cnt
`endif
);

  localparam logic [INDEX_WIDTH-1:0] INC_W = INDEX_WIDTH'(INC);
  localparam logic [INDEX_WIDTH-1:0] RST_W = INDEX_WIDTH'(RESET_VEC);

  pc_sel_e                sel;
  logic                   push;
  logic                   pop;
  logic                   ovf;
  logic                   unf;
  logic [INDEX_WIDTH-1:0] ras_top;
  logic [INDEX_WIDTH-1:0] pc_next;

  assign sel     = next_sel(stall, ret, call, jump, branch_taken);
  assign push    = (sel == SEL_CALL);
  assign pop     = (sel == SEL_RET);
  assign pc_plus = pc + INC_W;

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .WIDTH(INDEX_WIDTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(pc_plus),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .ovf      (ovf),
    .unf      (unf)
  );

  always_comb begin
    pc_next = pc_plus;
    unique case (sel)
      SEL_HOLD: pc_next = pc;
      SEL_RET:  pc_next = ras_empty ? pc_plus : ras_top;  // underflow falls through as sequential
      SEL_CALL: pc_next = jump_target;
      SEL_JMP:  pc_next = jump_target;
      SEL_BR:   pc_next = branch_target;
      SEL_INC:  pc_next = pc_plus;
      default:  pc_next = pc_plus;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RST_W;
      ras_err <= 1'b0;
    end else begin
      pc      <= pc_next;
      ras_err <= ras_err | ovf | unf;
    end
  end

`ifdef PC_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_cnt <= '0;
    else if (!stall) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule
